// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [SEL_WIDTH-1:0] sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out;
    logic                 error;
    logic                 zero;
    logic                 carry;
    logic                 overflow;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, out, error, zero, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, out, error, zero, carry, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshakes and iterative MULT/DIV into HI/LO
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WL   = WIDTH'(WIDTH);

    localparam logic [SEL_WIDTH-1:0] OP_ADD  = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] OP_AND  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] OP_OR   = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] OP_NOR  = SEL_WIDTH'(5);
    localparam logic [SEL_WIDTH-1:0] OP_NAND = SEL_WIDTH'(6);
    localparam logic [SEL_WIDTH-1:0] OP_XNOR = SEL_WIDTH'(7);
    localparam logic [SEL_WIDTH-1:0] OP_EQU  = SEL_WIDTH'(8);
    localparam logic [SEL_WIDTH-1:0] OP_GT   = SEL_WIDTH'(9);
    localparam logic [SEL_WIDTH-1:0] OP_LT   = SEL_WIDTH'(10);
    localparam logic [SEL_WIDTH-1:0] OP_ROR  = SEL_WIDTH'(11);
    localparam logic [SEL_WIDTH-1:0] OP_ROL  = SEL_WIDTH'(12);
    localparam logic [SEL_WIDTH-1:0] OP_MULT = SEL_WIDTH'(13);
    localparam logic [SEL_WIDTH-1:0] OP_DIV  = SEL_WIDTH'(14);
    localparam logic [SEL_WIDTH-1:0] OP_MFLO = SEL_WIDTH'(15);
    localparam logic [SEL_WIDTH-1:0] OP_MFHI = SEL_WIDTH'(16);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a, op_b, hi, lo;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   out_r;
    logic               error_r, zero_r, carry_r, ovf_r;

    logic               accept, start_mul, start_div;
    logic [WIDTH-1:0]   r_out, sh;
    logic               r_err, r_carry, r_ovf;
    logic [WIDTH:0]     sum, diff, mul_sum, div_sh, div_tr;

    assign accept    = bus.in_valid && (state == IDLE);
    assign start_mul = (bus.sel == OP_MULT);
    assign start_div = (bus.sel == OP_DIV) && (bus.b != '0);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_r;
    assign bus.error     = error_r;
    assign bus.zero      = zero_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = start_mul ? MUL : (start_div ? DIV : DONE);
            MUL, DIV: if (cnt == LAST) state_nxt = DONE;
            DONE:     if (bus.out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Single-cycle result, evaluated from the operands present on the accept edge
    always_comb begin
        r_out   = '0;
        r_err   = 1'b0;
        r_carry = 1'b0;
        r_ovf   = 1'b0;
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        sh      = bus.b % WL;
        case (bus.sel)
            OP_ADD: begin
                r_out   = sum[WIDTH-1:0];
                r_carry = sum[WIDTH];
                r_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                r_out   = diff[WIDTH-1:0];
                r_carry = diff[WIDTH];
                r_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  r_out = bus.a & bus.b;
            OP_OR:   r_out = bus.a | bus.b;
            OP_XOR:  r_out = bus.a ^ bus.b;
            OP_NOR:  r_out = ~(bus.a | bus.b);
            OP_NAND: r_out = ~(bus.a & bus.b);
            OP_XNOR: r_out = ~(bus.a ^ bus.b);
            OP_EQU:  r_out = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
            OP_GT:   r_out = {{(WIDTH-1){1'b0}}, bus.a > bus.b};
            OP_LT:   r_out = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_ROR:  r_out = (bus.a >> sh) | (bus.a << (WL - sh));
            OP_ROL:  r_out = (bus.a << sh) | (bus.a >> (WL - sh));
            OP_MULT: r_out = '0;
            OP_DIV:  r_err = 1'b1;  // only reached here when the divisor is zero
            OP_MFLO: r_out = lo;
            OP_MFHI: r_out = hi;
            default: r_err = 1'b1;
        endcase
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
        div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_tr  = div_sh - {1'b0, op_b};
        if (state == MUL)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (div_tr[WIDTH])
            acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_nxt = {div_tr[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
            out_r   <= '0;
            error_r <= 1'b0;
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            acc   <= {{WIDTH{1'b0}}, start_mul ? bus.b : bus.a};
            cnt   <= '0;
            if (start_mul || start_div) begin
                error_r <= 1'b0;
            end else begin
                out_r   <= r_out;
                error_r <= r_err;
                zero_r  <= (r_out == '0);
                carry_r <= r_carry;
                ovf_r   <= r_ovf;
            end
        end else if (state == MUL || state == DIV) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                hi      <= acc_nxt[2*WIDTH-1:WIDTH];
                lo      <= acc_nxt[WIDTH-1:0];
                out_r   <= acc_nxt[WIDTH-1:0];
                zero_r  <= (acc_nxt[WIDTH-1:0] == '0);
                carry_r <= (state == MUL) && (acc_nxt[2*WIDTH-1:WIDTH] != '0);
                ovf_r   <= 1'b0;
                error_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W = 8;

    typedef struct {
        int out;
        bit err;
        bit carry;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   m_hi = 0;
    int   m_lo = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .SEL_WIDTH(5)) bif ();

    alu_seq #(.WIDTH(W), .SEL_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned/signed interpretations
    function automatic exp_t model(input int ua, input int ub, input int s);
        exp_t e;
        int   sa, sb, r, k;
        e  = '{out: 0, err: 1'b0, carry: 1'b0, ovf: 1'b0};
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        k  = ub % W;
        case (s)
            0:  begin r = ua + ub; e.out = r & 255; e.carry = (r > 255); e.ovf = (sa + sb > 127) || (sa + sb < -128); end
            1:  begin r = ua - ub; e.out = r & 255; e.carry = (ua < ub);  e.ovf = (sa - sb > 127) || (sa - sb < -128); end
            2:  e.out = ua & ub;
            3:  e.out = ua | ub;
            4:  e.out = ua ^ ub;
            5:  e.out = ~(ua | ub) & 255;
            6:  e.out = ~(ua & ub) & 255;
            7:  e.out = ~(ua ^ ub) & 255;
            8:  e.out = (ua == ub) ? 1 : 0;
            9:  e.out = (ua > ub) ? 1 : 0;
            10: e.out = (ua < ub) ? 1 : 0;
            11: e.out = ((ua >> k) | (ua << (W - k))) & 255;
            12: e.out = ((ua << k) | (ua >> (W - k))) & 255;
            13: begin r = ua * ub; m_hi = r / 256; m_lo = r % 256; e.out = m_lo; e.carry = (m_hi != 0); end
            14: begin
                if (ub == 0) e.err = 1'b1;
                else begin m_lo = ua / ub; m_hi = ua % ub; e.out = m_lo; end
            end
            15: e.out = m_lo;
            16: e.out = m_hi;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bif.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q[0];
                chk("out", {24'd0, bif.out}, e.out);
                chk("error", bif.error, e.err);
                chk("carry", bif.carry, e.carry);
                chk("overflow", bif.overflow, e.ovf);
                chk("zero", bif.zero, (e.out == 0));
                chk("in_ready_busy", bif.in_ready, 0);
                if (bif.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic run_op(input int ta, input int tb, input int ts, input int exp_lat, input int hold);
        int lat;
        bif.a         = 8'(ta);
        bif.b         = 8'(tb);
        bif.sel       = 5'(ts);
        bif.in_valid  = 1'b1;
        bif.out_ready = (hold == 0);
        q.push_back(model(ta, tb, ts));
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.a        = 8'h5A;
        bif.b        = 8'hA5;
        lat = 1;
        while (!bif.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            chk("bp_in_ready", bif.in_ready, 0);
            bif.in_valid = 1'b1;
            bif.sel      = 5'(i);
            @(posedge clk); #1;
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        if (hold > 0) begin
            @(posedge clk); #1;
        end else begin
            if (lat > 1) begin
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        end
        chk("back_to_idle", bif.in_ready, 1);
        chk("valid_dropped", bif.out_valid, 0);
    endtask

    int va[13] = '{8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 9, 9, 9, 8'h81, 8'h80, 8'hFF, 0};
    int vb[13] = '{8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 9, 3, 3, 3, 1, 1, 0};
    int vs[13] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 1, 0, 31};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        bif.a         = '0;
        bif.b         = '0;
        bif.sel       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_out", bif.out, 0);
        chk("rst_flags", {bif.error, bif.zero, bif.carry, bif.overflow}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bif.in_ready, 1);

        run_op(100, 100, 0, 1, 0);
        chk("lit_add1", {bif.out, bif.carry, bif.overflow, bif.zero}, {8'd200, 3'b010});
        run_op(200, 100, 0, 1, 0);
        chk("lit_add2", {bif.out, bif.carry, bif.overflow}, {8'd44, 2'b10});
        run_op(5, 7, 1, 1, 0);
        chk("lit_sub", {bif.out, bif.carry, bif.overflow}, {8'hFE, 2'b10});
        run_op(8'h81, 9, 12, 1, 0);
        chk("lit_rol", bif.out, 8'h03);
        run_op(0, 0, 20, 1, 0);
        chk("lit_invalid", {bif.out, bif.error, bif.zero}, {8'd0, 2'b11});

        run_op(200, 3, 13, 9, 0);
        chk("lit_mult", {bif.out, bif.carry}, {8'h58, 1'b1});
        run_op(0, 0, 16, 1, 0);
        chk("lit_mfhi", bif.out, 8'h02);
        run_op(0, 0, 15, 1, 0);
        chk("lit_mflo", bif.out, 8'h58);

        run_op(200, 7, 14, 9, 0);
        chk("lit_div", {bif.out, bif.error}, {8'd28, 1'b0});
        run_op(0, 0, 16, 1, 0);
        chk("lit_div_rem", bif.out, 8'd4);
        run_op(7, 0, 14, 1, 0);
        chk("lit_div0", {bif.out, bif.error, bif.zero}, {8'd0, 2'b11});
        run_op(0, 0, 15, 1, 0);
        chk("lit_lo_kept", bif.out, 8'd28);

        for (int i = 0; i < 13; i++) run_op(va[i], vb[i], vs[i], 1, 0);

        run_op(8'h0F, 8'h33, 4, 1, 3);
        chk("lit_bp_xor", bif.out, 8'h3C);

        run_op(255, 255, 13, 9, 0);
        run_op(0, 0, 16, 1, 0);
        chk("lit_mfhi_ff", bif.out, 8'hFE);

        bif.a        = 8'd255;
        bif.b        = 8'd255;
        bif.sel      = 5'd13;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        m_hi = 0;
        m_lo = 0;
        #1;
        chk("abort_out_valid", bif.out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", bif.in_ready, 1);
        chk("abort_no_valid", bif.out_valid, 0);
        run_op(0, 0, 16, 1, 0);
        chk("lit_hi_cleared", bif.out, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
